// File: rtl/mem_stage.sv
// Memory-access stage: captures the execute bundle, runs loads/stores through a
// fixed-latency internal data memory, resolves branches and registers the write-back bundle.
//
// state  | meaning
// S_IDLE | ready to accept a bundle; single-cycle ops complete at the capture edge
// S_BUSY | memory access in flight; stall high, counter counts down to completion
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_in,
  input  logic       wr,
  input  logic       wm,
  input  logic       rm,
  input  logic       neq,
  input  logic       j,
  input  logic       jc,
  input  logic       zero,
  input  logic [7:0] ac_value,
  input  logic [7:0] jump_addr,
  input  logic [7:0] rs,
  output logic       stall,
  output logic       branch_taken,
  output logic [7:0] branch_target,
  output logic       wb_valid,
  output logic       wb_en,
  output logic [7:0] wb_data
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] C_LAT = 4'(MEM_LAT);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_wr, r_wm, r_rm;
  logic [7:0]        r_ac, r_rs;
  logic [7:0]        r_mem [DEPTH];
  logic              r_branch_taken, r_wb_valid, r_wb_en;
  logic [7:0]        r_branch_target, r_wb_data;

  logic              w_accept, w_is_mem, w_taken, w_complete, w_from_in;
  logic              w_c_wr, w_c_wm, w_c_rm;
  logic [7:0]        w_c_ac, w_c_rs, w_rd_data, w_wb_data;
  logic [ADDR_W-1:0] w_addr;

  assign stall    = (r_state == S_BUSY);
  // Gating with reset keeps the unreset memory from being written while reset is held.
  assign w_accept = reset & valid_in & ~stall;
  assign w_is_mem = rm | wm;
  assign w_taken  = j | (jc & (zero ^ neq));

  // Single-cycle completions use the live bundle; BUSY completions use the captured one.
  assign w_from_in = (r_state == S_IDLE);
  assign w_c_wr    = w_from_in ? wr       : r_wr;
  assign w_c_wm    = w_from_in ? wm       : r_wm;
  assign w_c_rm    = w_from_in ? rm       : r_rm;
  assign w_c_ac    = w_from_in ? ac_value : r_ac;
  assign w_c_rs    = w_from_in ? rs       : r_rs;
  assign w_addr    = w_c_ac[ADDR_W-1:0];
  assign w_rd_data = r_mem[w_addr];
  assign w_wb_data = (w_c_rm & ~w_c_wm) ? w_rd_data : w_c_ac;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mem && (MEM_LAT != 0)) begin
            w_state_nxt = S_BUSY;
            w_cnt_nxt   = C_LAT;
          end else begin
            w_complete = 1'b1;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
          w_complete  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr <= 1'b0;
      r_wm <= 1'b0;
      r_rm <= 1'b0;
      r_ac <= 8'h00;
      r_rs <= 8'h00;
    end else if (w_accept) begin
      r_wr <= wr;
      r_wm <= wm;
      r_rm <= rm;
      r_ac <= ac_value;
      r_rs <= rs;
    end
  end

  always_ff @(posedge clock) begin
    if (w_complete && w_c_wm) r_mem[w_addr] <= w_c_rs;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_branch_taken  <= 1'b0;
      r_branch_target <= 8'h00;
      r_wb_valid      <= 1'b0;
      r_wb_en         <= 1'b0;
      r_wb_data       <= 8'h00;
    end else begin
      r_branch_taken <= w_accept & w_taken;
      if (w_accept) r_branch_target <= jump_addr;
      r_wb_valid <= w_complete;
      r_wb_en    <= w_complete & w_c_wr;
      if (w_complete) r_wb_data <= w_wb_data;
    end
  end

  assign branch_taken  = r_branch_taken;
  assign branch_target = r_branch_target;
  assign wb_valid      = r_wb_valid;
  assign wb_en         = r_wb_en & r_wb_valid;
  assign wb_data       = r_wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a MEM_LAT=2 / ADDR_W=8 instance and a MEM_LAT=0 / ADDR_W=4
// instance share stimulus; each is checked only where its behaviour is defined.
module tb_mem_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid_in, wr, wm, rm, neq, j, jc, zero;
  logic [7:0] ac_value, jump_addr, rs;

  logic       s2, bt2, wv2, we2;
  logic [7:0] tg2, wd2;
  logic       s0, bt0, wv0, we0;
  logic [7:0] tg0, wd0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_stage #(.ADDR_W(8), .MEM_LAT(2)) u_d2 (
    .clock(clock), .reset(reset), .valid_in(valid_in), .wr(wr), .wm(wm), .rm(rm),
    .neq(neq), .j(j), .jc(jc), .zero(zero), .ac_value(ac_value), .jump_addr(jump_addr),
    .rs(rs), .stall(s2), .branch_taken(bt2), .branch_target(tg2), .wb_valid(wv2),
    .wb_en(we2), .wb_data(wd2)
  );

  mem_stage #(.ADDR_W(4), .MEM_LAT(0)) u_d0 (
    .clock(clock), .reset(reset), .valid_in(valid_in), .wr(wr), .wm(wm), .rm(rm),
    .neq(neq), .j(j), .jc(jc), .zero(zero), .ac_value(ac_value), .jump_addr(jump_addr),
    .rs(rs), .stall(s0), .branch_taken(bt0), .branch_target(tg0), .wb_valid(wv0),
    .wb_en(we0), .wb_data(wd0)
  );

  typedef struct {
    logic       wr, wm, rm, neq, j, jc, zero;
    logic [7:0] ac, ja, rs;
    logic       e_bt;
    logic [7:0] e_tg;
    logic       e_en;
    logic [7:0] e_wd;
    logic       chk2;
  } vec_t;

  vec_t tbl[13];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; wr = 0; wm = 0; rm = 0; neq = 0; j = 0; jc = 0; zero = 0;
    ac_value = 8'h00; jump_addr = 8'h00; rs = 8'h00;
  endtask

  task automatic drive(input logic wr_i, input logic wm_i, input logic rm_i, input logic j_i,
                       input logic [7:0] ac_i, input logic [7:0] rs_i);
    idle();
    valid_in = 1; wr = wr_i; wm = wm_i; rm = rm_i; j = j_i; ac_value = ac_i; rs = rs_i;
  endtask

  initial begin
    //            wr wm rm neq j jc z  ac     ja     rs     bt tg     en wd     chk2
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 8'h3C, 8'h00, 8'h00, 0, 8'h00, 1, 8'h3C, 1};
    tbl[1]  = '{0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h42, 8'h00, 1, 8'h42, 0, 8'h00, 1};
    tbl[2]  = '{0, 0, 0, 1, 0, 1, 1, 8'h01, 8'h42, 8'h00, 0, 8'h00, 0, 8'h01, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 1, 8'h02, 8'h55, 8'h00, 1, 8'h55, 0, 8'h02, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 8'h03, 8'h66, 8'h00, 0, 8'h00, 0, 8'h03, 1};
    tbl[5]  = '{0, 0, 0, 1, 1, 1, 1, 8'h04, 8'h80, 8'h00, 1, 8'h80, 0, 8'h04, 1};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, 0, 8'h9A, 8'h13, 8'h00, 1, 8'h13, 1, 8'h9A, 1};
    tbl[7]  = '{1, 1, 1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h11, 0, 8'h00, 1, 8'h05, 0};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h00, 0, 8'h00, 1, 8'h11, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 8'h37, 8'h00, 8'h9C, 0, 8'h00, 0, 8'h37, 0};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 0, 8'hF7, 8'h00, 8'h00, 0, 8'h00, 1, 8'h9C, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 0, 8'hF5, 8'h00, 8'h00, 0, 8'h00, 0, 8'h11, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 0, 0, 8'h15, 8'h21, 8'h00, 1, 8'h21, 0, 8'h11, 0};

    idle();
    reset = 0;
    #1;
    chk1("rst_stall2", s2, 0);   chk1("rst_bt2", bt2, 0);   chk8("rst_tg2", tg2, 8'h00);
    chk1("rst_wv2", wv2, 0);     chk1("rst_we2", we2, 0);   chk8("rst_wd2", wd2, 8'h00);
    chk1("rst_stall0", s0, 0);   chk1("rst_wv0", wv0, 0);   chk8("rst_wd0", wd0, 8'h00);
    tick(); tick();
    reset = 1;
    tick();

    // Store 0xA5 to 0x10 with two-cycle latency
    drive(0, 1, 0, 0, 8'h10, 8'hA5);
    tick(); idle();
    chk1("st_e0_stall", s2, 1); chk1("st_e0_wv", wv2, 0);
    tick();
    chk1("st_e1_stall", s2, 1); chk1("st_e1_wv", wv2, 0);
    tick();
    chk1("st_e2_stall", s2, 0); chk1("st_e2_wv", wv2, 1);
    chk8("st_e2_wd", wd2, 8'h10); chk1("st_e2_we", we2, 0);
    tick();
    chk1("st_e3_wv", wv2, 0);

    // Load it back while hostile bundles are offered during the stall
    drive(1, 0, 1, 0, 8'h10, 8'h00);
    tick();
    drive(1, 1, 0, 1, 8'h10, 8'hFF);
    jump_addr = 8'hEE;
    chk1("ld_e0_stall", s2, 1);
    tick();
    chk1("ld_e1_stall", s2, 1); chk1("ld_e1_bt", bt2, 0); chk1("ld_e1_wv", wv2, 0);
    tick(); idle();
    chk1("ld_e2_stall", s2, 0); chk1("ld_e2_wv", wv2, 1);
    chk1("ld_e2_we", we2, 1);   chk8("ld_e2_wd", wd2, 8'hA5); chk1("ld_e2_bt", bt2, 0);
    tick();
    chk1("ld_e3_wv", wv2, 0);   chk1("ld_e3_we", we2, 0);
    drive(1, 0, 1, 0, 8'h10, 8'h00);
    tick(); idle(); tick(); tick();
    chk1("ld2_wv", wv2, 1);     chk8("ld2_wd_unchanged", wd2, 8'hA5);
    tick();

    // Reset in the middle of a store must abort it
    drive(0, 1, 0, 0, 8'h20, 8'h00);
    tick(); idle(); tick(); tick(); tick();
    drive(0, 1, 0, 0, 8'h20, 8'h77);
    tick(); idle();
    chk1("ab_stall_before", s2, 1);
    reset = 0;
    #1;
    chk1("ab_stall_async", s2, 0);
    tick();
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      chk1($sformatf("ab_no_wv_%0d", k), wv2, 0);
      chk1($sformatf("ab_no_stall_%0d", k), s2, 0);
      tick();
    end
    drive(1, 0, 1, 0, 8'h20, 8'h00);
    tick(); idle(); tick(); tick();
    chk1("ab_rd_wv", wv2, 1);   chk8("ab_rd_wd", wd2, 8'h00);
    tick(); tick();

    // Single-cycle vectors: both instances, memory rows on the zero-latency one only
    for (int i = 0; i < 13; i++) begin
      idle();
      valid_in = 1; wr = tbl[i].wr; wm = tbl[i].wm; rm = tbl[i].rm; neq = tbl[i].neq;
      j = tbl[i].j; jc = tbl[i].jc; zero = tbl[i].zero;
      ac_value = tbl[i].ac; jump_addr = tbl[i].ja; rs = tbl[i].rs;
      tick(); idle();
      chk1($sformatf("v%0d_stall0", i), s0, 0);
      chk1($sformatf("v%0d_wv0", i), wv0, 1);
      chk1($sformatf("v%0d_we0", i), we0, tbl[i].e_en);
      chk8($sformatf("v%0d_wd0", i), wd0, tbl[i].e_wd);
      chk1($sformatf("v%0d_bt0", i), bt0, tbl[i].e_bt);
      if (tbl[i].e_bt) chk8($sformatf("v%0d_tg0", i), tg0, tbl[i].e_tg);
      if (tbl[i].chk2) begin
        chk1($sformatf("v%0d_stall2", i), s2, 0);
        chk1($sformatf("v%0d_wv2", i), wv2, 1);
        chk1($sformatf("v%0d_we2", i), we2, tbl[i].e_en);
        chk8($sformatf("v%0d_wd2", i), wd2, tbl[i].e_wd);
        chk1($sformatf("v%0d_bt2", i), bt2, tbl[i].e_bt);
        if (tbl[i].e_bt) chk8($sformatf("v%0d_tg2", i), tg2, tbl[i].e_tg);
      end
      tick();
      chk1($sformatf("v%0d_wv0_pulse", i), wv0, 0);
      chk1($sformatf("v%0d_we0_pulse", i), we0, 0);
      chk1($sformatf("v%0d_bt0_pulse", i), bt0, 0);
      if (tbl[i].chk2) chk1($sformatf("v%0d_bt2_pulse", i), bt2, 0);
      tick(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 8-bit pipeline.
- Consumes the execute-stage bundle: accumulator result, zero flag, jump target, register value and control bits (wr, wm, rm, neq, j, jc).
- Performs data-memory loads and stores through an internal multi-cycle memory model, resolves jumps/conditional jumps, and delivers a registered write-back bundle to the WB stage.
- Asserts stall back toward execute while a memory access is in progress.

Parameters:
ADDR_W, 8, data-memory address width; depth = 2^ADDR_W bytes; address = low ADDR_W bits of ac_value
MEM_LAT, 2, memory access latency in cycles (0..15); 0 = single-cycle access

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
valid_in  input  1  execute bundle valid this cycle
wr  input  1  write register file at write-back
wm  input  1  store rs to mem[ac_value]
rm  input  1  load mem[ac_value] into write-back data
neq  input  1  conditional-jump sense: 1 = jump if not zero, 0 = jump if zero
j  input  1  unconditional jump
jc  input  1  conditional jump
zero  input  1  zero flag from execute
ac_value  input  8  execute result / memory address
jump_addr  input  8  PC-relative jump target
rs  input  8  register value; store data
stall  output  1  execute must hold its bundle; mem_stage is busy
branch_taken  output  1  one-cycle pulse: redirect fetch
branch_target  output  8  target PC, valid with branch_taken
wb_valid  output  1  one-cycle pulse: write-back bundle valid
wb_en  output  1  register-file write enable, qualified by wb_valid
wb_data  output  8  write-back data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, stall=0, branch_taken=0, branch_target=0, wb_valid=0, wb_en=0, wb_data=0. Memory contents are not cleared.
- Capture: a bundle is accepted on a rising edge with valid_in=1 and stall=0. All fields are registered internally at that edge.
- States: IDLE, BUSY.
- IDLE, accepted non-memory op (rm=0, wm=0), or memory op with MEM_LAT=0:
  - Access performed at the capture edge.
  - wb_valid=1 for the following cycle.
  - State stays IDLE. Latency is 1 cycle.
- IDLE, accepted memory op with MEM_LAT>0:
  - Go to BUSY; counter=MEM_LAT.
  - stall=1 combinationally, from state==BUSY.
- BUSY:
  - Each edge decrements the counter.
  - On the edge where counter==1: perform the store or load, assert wb_valid for the next cycle, and return to IDLE.
  - stall is high for exactly MEM_LAT cycles after the capture edge.
  - valid_in is ignored while BUSY.
- Store: mem[ac_value[ADDR_W-1:0]] <= rs, written on the completing edge. wb_data = ac_value.
- Load: wb_data = mem[address], read on the completing edge.
- Both rm and wm set: the store wins, the read is ignored, and wb_data = ac_value.
- Non-memory op: wb_data = ac_value.
- wb_en = captured wr; it is meaningful only while wb_valid=1. wb_valid=0 forces wb_en=0.
- Branch resolution happens at the capture edge, independent of memory latency:
  - taken = j | (jc & (zero ^ neq)).
  - branch_taken pulses for one cycle after the capture edge; branch_target = jump_addr.
  - j and jc both set: taken (j dominates).
- Reset asserted mid-BUSY: access aborted, store not performed, no wb_valid, state IDLE.
- Address wrap: ac_value bits above ADDR_W are ignored.
- Pulses: branch_taken and wb_valid are never held for more than one cycle per accepted bundle.

Test Plan:
- Reset, then store with MEM_LAT=2: ac_value=0x10, rs=0xA5, wm=1, valid_in=1 -> stall=1 for 2 cycles; mem[0x10]=0xA5; wb_valid pulses 2 cycles after capture with wb_data=0x10, wb_en=0.
- Load after the store above: rm=1, wr=1, ac_value=0x10 -> stall 2 cycles; then wb_valid=1, wb_en=1, wb_data=0xA5. During the stall, valid_in=1 with different data is ignored.
- ALU op: wr=1, ac_value=0x3C, no rm/wm -> no stall; next cycle wb_valid=1, wb_data=0x3C, wb_en=1.
- Conditional jump: jc=1, neq=1, zero=0, jump_addr=0x42 -> branch_taken=1 and branch_target=0x42 for one cycle. Repeat with zero=1 -> branch_taken stays 0. Repeat with neq=0, zero=1 -> taken.
- Reset during BUSY: store ac_value=0x20, rs=0x77; drop reset after 1 cycle -> stall=0, wb_valid never asserts, mem[0x20] unchanged (preload 0x00, read back 0x00).
- MEM_LAT=0 build: load and store complete with stall never asserted; rm=wm=1, ac_value=0x05, rs=0x11 -> mem[0x05]=0x11, wb_data=0x05.
